// File: rtl/bcd_updown_counter_if.sv
// Control and digit bundle between the BCD counter and whatever drives it
// (host logic on the master side, the counter itself on the slave side).
// The digit outputs feed the 7-segment decoders directly.
interface bcd_updown_counter_if;
    logic       en;
    logic       up_down;
    logic       load;
    logic [3:0] load_ones;
    logic [3:0] load_tens;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       tick;
    logic       carry;

    modport master (
        output en,
        output up_down,
        output load,
        output load_ones,
        output load_tens,
        input  ones,
        input  tens,
        input  tick,
        input  carry
    );

    modport slave (
        input  en,
        input  up_down,
        input  load,
        input  load_ones,
        input  load_tens,
        output ones,
        output tens,
        output tick,
        output carry
    );
endinterface

// File: rtl/bcd_updown_counter.sv
// Two-digit (00-99) BCD up/down counter with a built-in clock prescaler.
// A free-running prescaler produces one step event every DIV_COUNT clocks;
// on that step the digits move up or down by one when enabled. A parallel
// load overrides the step and restarts the prescaler so the next step is a
// full period after the load. Digits are guaranteed to stay within 0-9.
module bcd_updown_counter #(
    parameter int DIV_COUNT = 50_000_000
) (
    input logic                  clk,
    input logic                  rst,
    bcd_updown_counter_if.slave  bus
);

    localparam int DIV_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam logic [DIV_W-1:0] LAST_COUNT = DIV_W'(DIV_COUNT - 1);

    logic [DIV_W-1:0] r_divCnt;
    logic [3:0]       r_ones;
    logic [3:0]       r_tens;
    logic             r_tick;
    logic             r_carry;

    logic             w_step;
    logic             w_countEn;
    logic [3:0]       w_loadOnes;
    logic [3:0]       w_loadTens;
    logic [3:0]       w_nextOnes;
    logic [3:0]       w_nextTens;
    logic             w_wrap;

    assign w_step    = (r_divCnt == LAST_COUNT);
    assign w_countEn = w_step & bus.en;

    // A non-BCD load value is replaced by zero so the decoders never see 10-15.
    assign w_loadOnes = (bus.load_ones > 4'd9) ? 4'd0 : bus.load_ones;
    assign w_loadTens = (bus.load_tens > 4'd9) ? 4'd0 : bus.load_tens;

    // Next digit pair for one step in the requested direction, plus the wrap flag.
    always_comb begin
        w_nextOnes = r_ones;
        w_nextTens = r_tens;
        w_wrap     = 1'b0;
        if (bus.up_down) begin
            if (r_ones >= 4'd9) begin
                w_nextOnes = 4'd0;
                if (r_tens >= 4'd9) begin
                    w_nextTens = 4'd0;
                    w_wrap     = 1'b1;
                end else begin
                    w_nextTens = r_tens + 4'd1;
                end
            end else begin
                w_nextOnes = r_ones + 4'd1;
            end
        end else begin
            if (r_ones == 4'd0) begin
                w_nextOnes = 4'd9;
                if (r_tens == 4'd0) begin
                    w_nextTens = 4'd9;
                    w_wrap     = 1'b1;
                end else begin
                    w_nextTens = r_tens - 4'd1;
                end
            end else begin
                w_nextOnes = r_ones - 4'd1;
            end
        end
    end

    // Prescaler: free-running modulo-DIV_COUNT counter, restarted by a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_divCnt <= '0;
        end else if (bus.load || w_step) begin
            r_divCnt <= '0;
        end else begin
            r_divCnt <= r_divCnt + DIV_W'(1);
        end
    end

    // Tick marks every prescaler period regardless of enable or load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_step;
        end
    end

    // Digit registers: load beats a step; carry pulses only on an enabled wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ones  <= 4'd0;
            r_tens  <= 4'd0;
            r_carry <= 1'b0;
        end else if (bus.load) begin
            r_ones  <= w_loadOnes;
            r_tens  <= w_loadTens;
            r_carry <= 1'b0;
        end else if (w_countEn) begin
            r_ones  <= w_nextOnes;
            r_tens  <= w_nextTens;
            r_carry <= w_wrap;
        end else begin
            r_carry <= 1'b0;
        end
    end

    assign bus.ones  = r_ones;
    assign bus.tens  = r_tens;
    assign bus.tick  = r_tick;
    assign bus.carry = r_carry;

endmodule
